apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 97 +++++++++
 1 files changed

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master that turns a command handshake into
// a SETUP/ACCESS transfer and aborts it after TIMEOUT wait states.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              pwrite_q, pwrite_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [7:0]        wait_q, wait_d;
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign psel      = state_q != IDLE;
    assign penable   = state_q == ACCESS;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                state_d  = SETUP;
                paddr_d  = cmd_addr;
                pwdata_d = cmd_wdata;
                pwrite_d = cmd_write;
                wait_d   = '0;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (pready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = pwrite_q ? '0 : prdata;
            end else if (TIMEOUT != 0 && wait_q == TMO) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end else begin
                wait_d = wait_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_q      <= wait_d;
        end
    end
endmodule
